// File: rtl/fp_matmul_sequencer.sv
// Sequencer for C = A x B over N x N FP32 matrices, time-sharing one external
// multiplier and one external adder across all N^3 multiply-accumulate terms.
module fp_matmul_sequencer #(
    parameter int N      = 4,
    parameter int IDX_W  = 2,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              nan_seen,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       a_rdata,
    input  logic [31:0]       b_rdata,
    output logic [31:0]       mul_a,
    output logic [31:0]       mul_b,
    input  logic [31:0]       mul_z,
    output logic [31:0]       add_a,
    output logic [31:0]       add_b,
    input  logic [31:0]       add_z,
    output logic [ADDR_W-1:0] c_addr,
    output logic              c_we,
    output logic [31:0]       c_wdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_MUL, S_ACC, S_WRITE, S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t            state, state_nx;
    logic [IDX_W-1:0]  i, j, k;
    logic [31:0]       prod, acc;
    logic [ADDR_W-1:0] a_addr_q, b_addr_q, c_addr_q;
    logic              add_nan;

    assign add_nan = (add_z[30:23] == 8'hFF) && (add_z[22:0] != 23'd0);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_READ;
            S_READ:  state_nx = S_MUL;
            S_MUL:   state_nx = S_ACC;
            S_ACC:   state_nx = (k == LAST) ? S_WRITE : S_READ;
            S_WRITE: state_nx = (i == LAST && j == LAST) ? S_DONE : S_READ;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Indices wrap naturally because N is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            i        <= '0;
            j        <= '0;
            k        <= '0;
            prod     <= '0;
            acc      <= '0;
            nan_seen <= 1'b0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            c_addr_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    i        <= '0;
                    j        <= '0;
                    k        <= '0;
                    acc      <= '0;
                    nan_seen <= 1'b0;
                end
                S_READ: begin
                    a_addr_q <= {i, k};
                    b_addr_q <= {k, j};
                end
                S_MUL: prod <= mul_z;
                S_ACC: begin
                    acc <= add_z;
                    k   <= k + 1'b1;
                    if (add_nan) nan_seen <= 1'b1;
                end
                S_WRITE: begin
                    c_addr_q <= {i, j};
                    acc      <= '0;
                    j        <= j + 1'b1;
                    if (j == LAST) i <= i + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Addresses are driven live in their own state and hold otherwise.
    always_comb begin
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
        a_addr  = a_addr_q;
        b_addr  = b_addr_q;
        c_addr  = c_addr_q;
        mul_a   = '0;
        mul_b   = '0;
        add_a   = '0;
        add_b   = '0;
        c_we    = 1'b0;
        c_wdata = '0;
        case (state)
            S_READ: begin
                a_addr = {i, k};
                b_addr = {k, j};
            end
            S_MUL: begin
                mul_a = a_rdata;
                mul_b = b_rdata;
            end
            S_ACC: begin
                add_a = acc;
                add_b = prod;
            end
            S_WRITE: begin
                c_we    = 1'b1;
                c_addr  = {i, j};
                c_wdata = acc;
            end
            default: ;
        endcase
    end

endmodule
